// File: rtl/scan_pkg.sv
// Shared types and helpers for the nested scan streamer: pattern modes, FSM
// states and the small pattern-select helper used by the generator.
package scan_pkg;

  localparam int SCAN_MODE_W = 2;

  typedef enum logic [SCAN_MODE_W-1:0] {
    PARITY     = 2'd0,
    INV_PARITY = 2'd1,
    INDEX      = 2'd2,
    GRAY       = 2'd3
  } scan_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // The two parity modes share one base value; only the inverting one flips it.
  function automatic logic scan_mode_inverts(input scan_mode_e m);
    return (m == INV_PARITY);
  endfunction

endpackage

// File: rtl/scan_pattern_gen.sv
// Combinational pattern generator: maps an element index to its W-bit value
// for the selected mode, then adds the run offset modulo 2^W.
module scan_pattern_gen
  import scan_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int W     = 8
) (
  input  logic [IDX_W-1:0] n,
  input  scan_mode_e       mode,
  input  logic [W-1:0]     offset,
  output logic [W-1:0]     data
);

  logic [W-1:0] parity_val;
  logic [W-1:0] index_val;
  logic [W-1:0] gray_val;
  logic [W-1:0] pat;

  // Size casts zero-extend or truncate the index to the output width.
  assign index_val = W'(n);
  assign gray_val  = W'(n ^ (n >> 1));

  always_comb begin
    parity_val    = '0;
    parity_val[0] = n[0];
    pat           = parity_val;
    case (mode)
      PARITY, INV_PARITY: pat = scan_mode_inverts(mode) ? ~parity_val : parity_val;
      INDEX:              pat = index_val;
      GRAY:               pat = gray_val;
      default:            pat = parity_val;
    endcase
    data = pat + offset;
  end

endmodule

// File: rtl/nested_scan_streamer.sv
// Walks a ROWS x COLS grid in row- or column-major order and streams one
// pattern element per valid/ready beat, with abort and a done pulse.
module nested_scan_streamer
  import scan_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 8,
  parameter int W    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [1:0]                              mode,
  input  logic                                    col_major,
  input  logic [W-1:0]                            offset,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [W-1:0]                            out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                                    out_last
);

  localparam int IDX_W = ((ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  scan_mode_e       mode_q, mode_d;
  logic             col_major_q, col_major_d;
  logic [W-1:0]     offset_q, offset_d;
  logic             busy_q, done_q, valid_q, last_q;
  logic [W-1:0]     data_q;
  logic [IDX_W-1:0] n_d;
  logic [W-1:0]     pat_d;
  logic             handshake;
  logic             at_last;

  assign handshake = valid_q && out_ready;
  assign at_last   = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Next-state, counter advance and start-time latching of the run settings.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    mode_d      = mode_q;
    col_major_d = col_major_q;
    offset_d    = offset_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          row_d       = '0;
          col_d       = '0;
          mode_d      = scan_mode_e'(mode);
          col_major_d = col_major;
          offset_d    = offset;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
        end else if (handshake) begin
          if (at_last) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end else if (!col_major_q) begin
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            if (row_q == ROW_MAX) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The element index is order independent: row-major numbering always.
  assign n_d = IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);

  scan_pattern_gen #(
    .IDX_W (IDX_W),
    .W     (W)
  ) u_pattern (
    .n      (n_d),
    .mode   (mode_d),
    .offset (offset_d),
    .data   (pat_d)
  );

  // Outputs are registered from the next-state view so element (0,0) is
  // presented the cycle after start, and zeroed outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= PARITY;
      col_major_q <= 1'b0;
      offset_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      col_major_q <= col_major_d;
      offset_q    <= offset_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
      valid_q     <= (state_d == RUN);
      last_q      <= (state_d == RUN) && (row_d == ROW_MAX) && (col_d == COL_MAX);
      data_q      <= (state_d == RUN) ? pat_d : '0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_nested_scan_streamer.sv
// Directed scoreboard bench for nested_scan_streamer at the default 4x8x8
// geometry: expected beats are queued at start and popped on each handshake.
module tb_nested_scan_streamer;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int W    = 8;

  typedef struct {
    logic [1:0] row;
    logic [2:0] col;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic       col_major;
  logic [7:0] offset;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_row;
  logic [2:0] out_col;
  logic       out_last;

  beat_t sb[$];
  int    checks;
  int    passed;
  int    beat_num;

  nested_scan_streamer #(
    .ROWS (ROWS),
    .COLS (COLS),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .col_major (col_major),
    .offset    (offset),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input int m, input int n, input logic [7:0] off);
    logic [7:0] p;
    case (m)
      0:       p = 8'(n & 1);
      1:       p = 8'hFF ^ 8'(n & 1);
      2:       p = 8'(n);
      default: p = 8'(n ^ (n >> 1));
    endcase
    return p + off;
  endfunction

  task automatic checkOutput(input string tag);
    beat_t e;
    if (sb.size() == 0) begin
      check({tag, "_extra_beat"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_row"},  32'(out_row),  32'(e.row));
      check({tag, "_col"},  32'(out_col),  32'(e.col));
      check({tag, "_data"}, 32'(out_data), 32'(e.data));
      check({tag, "_last"}, 32'(out_last), 32'(e.last));
      beat_num++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (out_valid && out_ready) checkOutput("beat");
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_row"},   32'(out_row),   32'd0);
    check({tag, "_col"},   32'(out_col),   32'd0);
  endtask

  // Queues the whole expected run, then pulses start for one edge.
  task automatic applyStimulus(input int m, input bit cm, input logic [7:0] off);
    int outer_n = cm ? COLS : ROWS;
    int inner_n = cm ? ROWS : COLS;
    beat_t b;
    sb.delete();
    beat_num = 0;
    for (int o = 0; o < outer_n; o++) begin
      for (int i = 0; i < inner_n; i++) begin
        int r = cm ? i : o;
        int c = cm ? o : i;
        b.row  = 2'(r);
        b.col  = 3'(c);
        b.data = model(m, r * COLS + c, off);
        b.last = (r == ROWS - 1) && (c == COLS - 1);
        sb.push_back(b);
      end
    end
    mode      = 2'(m);
    col_major = cm;
    offset    = off;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_busy",  32'(busy),      32'd1);
    if (out_valid && out_ready) checkOutput("beat");
    @(posedge clk);
    #1;
  endtask

  task automatic runBeats(input int target);
    int budget = 200;
    while (beat_num < target && budget > 0) begin
      cycle();
      budget--;
    end
    check("beats_reached", 32'(beat_num >= target), 32'd1);
  endtask

  task automatic runToEnd(input string tag, input bit start_in_done);
    int budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done),      32'd1);
    check({tag, "_done_busy"},  32'(busy),      32'd0);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_after_done"}, 32'(done), 32'd0);
    check({tag, "_after_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    beat_num  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 2'd0;
    col_major = 1'b0;
    offset    = 8'd0;
    out_ready = 1'b1;

    #2;
    checkIdle("reset");
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] mode 0 row-major");
    applyStimulus(0, 1'b0, 8'd0);
    runToEnd("run_parity", 1'b0);

    $display("[TB] mode 1 offset 10, start held through DONE");
    applyStimulus(1, 1'b0, 8'd10);
    runToEnd("run_invparity", 1'b1);

    $display("[TB] mode 2 column-major");
    applyStimulus(2, 1'b1, 8'd0);
    runToEnd("run_colmajor", 1'b0);

    $display("[TB] backpressure with mid-run setting changes");
    applyStimulus(2, 1'b0, 8'd0);
    mode      = 2'd3;
    offset    = 8'h55;
    col_major = 1'b1;
    runBeats(5);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data",  32'(out_data),  32'd5);
      check("stall_row",   32'(out_row),   32'd0);
      check("stall_col",   32'(out_col),   32'd5);
      check("stall_last",  32'(out_last),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    runToEnd("run_backpressure", 1'b0);
    check("backpressure_beats", 32'(beat_num), 32'(ROWS * COLS));

    $display("[TB] second start ignored, then abort");
    applyStimulus(2, 1'b0, 8'd0);
    runBeats(3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    runBeats(10);
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkIdle("abort");
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] fresh start after abort");
    applyStimulus(3, 1'b0, 8'd1);
    runToEnd("run_gray", 1'b0);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(2, 1'b0, 8'd3);
    runBeats(6);
    #2;
    rst = 1'b1;
    #1;
    checkIdle("async_rst");
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_last", 32'(out_last), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_busy",  32'(busy),      32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
